// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC owner, single-outstanding imem requests, IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            id_valid,
   output logic [31:0]     id_instr,
   output logic [6:0]      id_op,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic            fetch_fault
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   logic [2:0]      r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_id_valid;
   logic [31:0]     r_id_instr;
   logic [XLEN-1:0] r_id_pc;
   logic            r_hold_valid;
   logic [31:0]     r_hold_instr;
   logic [XLEN-1:0] r_hold_pc;
   logic            r_fault;

   logic [2:0]      w_state_n;
   logic [XLEN-1:0] w_pc_n;
   logic            w_id_valid_n;
   logic [31:0]     w_id_instr_n;
   logic [XLEN-1:0] w_id_pc_n;
   logic            w_hold_valid_n;
   logic [31:0]     w_hold_instr_n;
   logic [XLEN-1:0] w_hold_pc_n;
   logic            w_fault_n;

   logic            w_free;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_tgt;
   logic            w_misalign;

   assign w_free     = !r_id_valid || !stall;
   assign w_pc_plus4 = r_pc + XLEN'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_tgt      = redirect_pc;
   assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
   // Low bits are dropped so every fetch stays word aligned.
   assign w_tgt      = redirect_pc & ~XLEN'(3);
   assign w_misalign = 1'b0;
`endif

   always_comb begin
      w_state_n      = r_state;
      w_pc_n         = r_pc;
      w_id_valid_n   = r_id_valid;
      w_id_instr_n   = r_id_instr;
      w_id_pc_n      = r_id_pc;
      w_hold_valid_n = r_hold_valid;
      w_hold_instr_n = r_hold_instr;
      w_hold_pc_n    = r_hold_pc;
      w_fault_n      = r_fault;

      if (r_id_valid && !stall)
         w_id_valid_n = 1'b0;

      unique case (r_state)
         S_IDLE: w_state_n = S_REQ;
         S_REQ: begin
            if (imem_req_ready)
               w_state_n = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_pc_n = w_pc_plus4;
               if (w_free) begin
                  w_id_valid_n = 1'b1;
                  w_id_instr_n = imem_rsp_data;
                  w_id_pc_n    = r_pc;
                  w_state_n    = S_REQ;
               end else begin
                  w_hold_valid_n = 1'b1;
                  w_hold_instr_n = imem_rsp_data;
                  w_hold_pc_n    = r_pc;
                  w_state_n      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall) begin
               w_id_valid_n   = 1'b1;
               w_id_instr_n   = r_hold_instr;
               w_id_pc_n      = r_hold_pc;
               w_hold_valid_n = 1'b0;
               w_state_n      = S_REQ;
            end
         end
         S_DRAIN: begin
            if (imem_rsp_valid)
               w_state_n = S_REQ;
         end
         S_FAULT: w_id_valid_n = 1'b0;
         default: w_state_n = S_IDLE;
      endcase

      // Redirect wins over stall and any load computed above.
      if (redirect && (r_state != S_FAULT)) begin
         w_pc_n         = w_tgt;
         w_id_valid_n   = 1'b0;
         w_hold_valid_n = 1'b0;
         unique case (r_state)
            S_REQ:   w_state_n = imem_req_ready ? S_DRAIN : S_REQ;
            S_WAIT:  w_state_n = imem_rsp_valid ? S_REQ : S_DRAIN;
            S_DRAIN: w_state_n = imem_rsp_valid ? S_REQ : S_DRAIN;
            default: w_state_n = S_REQ;
         endcase
         if (w_misalign) begin
            w_fault_n = 1'b1;
            w_state_n = S_FAULT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_id_valid   <= 1'b0;
         r_id_instr   <= '0;
         r_id_pc      <= '0;
         r_hold_valid <= 1'b0;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_pc         <= w_pc_n;
         r_id_valid   <= w_id_valid_n;
         r_id_instr   <= w_id_instr_n;
         r_id_pc      <= w_id_pc_n;
         r_hold_valid <= w_hold_valid_n;
         r_hold_instr <= w_hold_instr_n;
         r_hold_pc    <= w_hold_pc_n;
         r_fault      <= w_fault_n;
      end
   end

   assign imem_req_valid = (r_state == S_REQ);
   assign imem_req_addr  = r_pc;
   assign id_valid       = r_id_valid;
   assign id_instr       = r_id_instr;
   assign id_op          = r_id_instr[6:0];
   assign id_pc          = r_id_pc;
   assign id_pc_plus4    = r_id_pc + XLEN'(4);
   assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model pushes expected {pc,instr},
// IF/ID consumption pops and compares.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [6:0]  id_op;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        fetch_fault;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
      .id_valid(id_valid), .id_instr(id_instr), .id_op(id_op),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          consumed = 0;
   int          rsp_delay = 0;
   logic [63:0] q[$];
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[24:0], 7'h13};
   endfunction

   task automatic tick();
      logic        hs;
      logic [31:0] a;
      logic [63:0] e;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      if (id_valid && !stall && !redirect) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL consume_empty pc=%h instr=%h", id_pc, id_instr);
         end else begin
            e = q.pop_front();
            consumed++;
            if ({id_pc, id_instr} !== e) begin
               errors++;
               $display("FAIL consume got pc=%h instr=%h want pc=%h instr=%h",
                        id_pc, id_instr, e[63:32], e[31:0]);
            end
         end
      end
      @(posedge clk);
      #1;
      if (hs) q.push_back({a, mem(a)});
      if (redirect) q.delete();
      imem_rsp_valid = 1'b0;
      if (hs) begin
         pend      = 1'b1;
         pend_cnt  = rsp_delay;
         pend_addr = a;
      end
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem(pend_addr);
            pend           = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      imem_req_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({imem_req_valid, id_valid, fetch_fault} !== 3'b000) begin
         errors++;
         $display("FAIL rst_flags got %b want 000",
                  {imem_req_valid, id_valid, fetch_fault});
      end
      checks++;
      if ({id_instr, id_pc} !== 64'h0) begin
         errors++;
         $display("FAIL rst_ifid got %h want 0", {id_instr, id_pc});
      end
      rst_n = 1'b1;
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_noreq got %b want 0", imem_req_valid);
      end
      tick();
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL first_req got %b/%h want 1/0", imem_req_valid, imem_req_addr);
      end
      tick();
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_noreq got %b want 0", imem_req_valid);
      end
      tick();
      checks++;
      if ({id_valid, id_op, id_pc, id_pc_plus4} !== {1'b1, 7'h13, 32'h0, 32'h4}) begin
         errors++;
         $display("FAIL first_ifid got v=%b op=%h pc=%h p4=%h want 1/13/0/4",
                  id_valid, id_op, id_pc, id_pc_plus4);
      end
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin
         errors++;
         $display("FAIL second_req got %b/%h want 1/4", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_ready_low();
      tick();
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL ready_low_stable got %b/%h want 1/8",
                     imem_req_valid, imem_req_addr);
         end
         tick();
      end
      imem_req_ready = 1'b1;
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin
         errors++;
         $display("FAIL ready_hi_req got %b/%h want 1/8", imem_req_valid, imem_req_addr);
      end
      tick();
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL ready_accept got %b want 0", imem_req_valid);
      end
      tick();
   endtask

   task automatic test_stall_hold();
      stall = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({imem_req_valid, id_valid, id_pc, id_instr} !==
             {1'b0, 1'b1, 32'h8, mem(32'h8)}) begin
            errors++;
            $display("FAIL hold_frozen got rv=%b v=%b pc=%h instr=%h want 0/1/8/%h",
                     imem_req_valid, id_valid, id_pc, id_instr, mem(32'h8));
         end
         tick();
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({id_valid, id_pc, imem_req_valid, imem_req_addr} !==
          {1'b1, 32'hC, 1'b1, 32'h10}) begin
         errors++;
         $display("FAIL hold_release got v=%b pc=%h rv=%b addr=%h want 1/c/1/10",
                  id_valid, id_pc, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect();
      rsp_delay = 1;
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      rsp_delay = 0;
      checks++;
      if ({id_valid, imem_req_valid} !== 2'b00) begin
         errors++;
         $display("FAIL drain_state got v=%b rv=%b want 0/0", id_valid, imem_req_valid);
      end
      tick();
      checks++;
      if ({id_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100}) begin
         errors++;
         $display("FAIL drain_exit got v=%b rv=%b addr=%h want 0/1/100",
                  id_valid, imem_req_valid, imem_req_addr);
      end
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h140;
      tick();
      redirect = 1'b0;
      checks++;
      if ({id_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h140}) begin
         errors++;
         $display("FAIL redir_same_cycle got v=%b rv=%b addr=%h want 0/1/140",
                  id_valid, imem_req_valid, imem_req_addr);
      end
      tick();
      tick();
      checks++;
      if ({id_valid, id_pc} !== {1'b1, 32'h140}) begin
         errors++;
         $display("FAIL redir_target_fetch got %b/%h want 1/140", id_valid, id_pc);
      end
   endtask

   task automatic test_redirect_hold();
      stall = 1'b1;
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      checks++;
      if ({id_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL hold_flush got v=%b rv=%b addr=%h want 0/1/200",
                  id_valid, imem_req_valid, imem_req_addr);
      end
      tick();
      tick();
      checks++;
      if ({id_valid, id_pc} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL hold_flush_load got %b/%h want 1/200", id_valid, id_pc);
      end
      stall = 1'b0;
   endtask

   task automatic test_wrap();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      tick();
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         errors++;
         $display("FAIL wrap_req got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr);
      end
      tick();
      tick();
      checks++;
      if ({id_valid, id_pc, id_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
         errors++;
         $display("FAIL wrap_ifid got v=%b pc=%h p4=%h want 1/fffffffc/0",
                  id_valid, id_pc, id_pc_plus4);
      end
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL wrap_next got %b/%h want 1/0", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_stream();
      int c0;
      c0 = consumed;
      for (int i = 0; i < 300; i++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         rsp_delay = $urandom_range(0, 2);
         tick();
      end
      imem_req_ready = 1'b1;
      stall = 1'b0;
      rsp_delay = 0;
      repeat (6) tick();
      checks++;
      if (consumed - c0 < 20) begin
         errors++;
         $display("FAIL stream_progress got %0d want >=20", consumed - c0);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (!imem_req_valid && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (imem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_find_req got %b want 1", imem_req_valid);
      end
      rsp_delay = 2;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req_valid, id_valid, id_pc, id_instr} !== 66'h0) begin
         errors++;
         $display("FAIL mid_reset got rv=%b v=%b pc=%h instr=%h want 0",
                  imem_req_valid, id_valid, id_pc, id_instr);
      end
      q.delete();
      tick();
      rst_n = 1'b1;
      rsp_delay = 0;
      tick();
      checks++;
      if ({imem_req_valid, imem_req_addr, imem_rsp_valid} !== {1'b1, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL mid_restart got rv=%b addr=%h rsp=%b want 1/0/1",
                  imem_req_valid, imem_req_addr, imem_rsp_valid);
      end
      tick();
      checks++;
      if ({imem_req_valid, id_valid} !== 2'b00) begin
         errors++;
         $display("FAIL mid_stale_rsp got rv=%b v=%b want 0/0", imem_req_valid, id_valid);
      end
      tick();
      checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, mem(32'h0)}) begin
         errors++;
         $display("FAIL mid_first got v=%b pc=%h instr=%h want 1/0/%h",
                  id_valid, id_pc, id_instr, mem(32'h0));
      end
   endtask

   task automatic test_misalign();
      imem_req_ready = 1'b1;
      stall = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({fetch_fault, imem_req_valid, id_valid} !== 3'b100) begin
            errors++;
            $display("FAIL fault_state got f=%b rv=%b v=%b want 1/0/0",
                     fetch_fault, imem_req_valid, id_valid);
         end
         tick();
      end
`else
      begin
         int n;
         n = 0;
         while (!imem_req_valid && n < 10) begin
            checks++;
            if (fetch_fault !== 1'b0) begin
               errors++;
               $display("FAIL nofault_flag got %b want 0", fetch_fault);
            end
            tick();
            n++;
         end
         checks++;
         if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL misalign_masked got %b/%h want 1/100",
                     imem_req_valid, imem_req_addr);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_ready_low();
      test_stall_hold();
      test_redirect();
      test_redirect_hold();
      test_wrap();
      test_stream();
      test_reset_mid();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
